// File: rtl/warp_regfile_pkg.sv
// -----------------------------------------------------------------------------
// warp_regfile_pkg
// Shared types and helpers for the warp register file:
//   - index width derivation (WARP_W / REG_AW), never narrower than one bit
//   - clear-sequencer state encoding
//   - flat-bus index helpers for the per-port, per-lane read buses
// -----------------------------------------------------------------------------
package warp_regfile_pkg;

    // Width of an index into n entries; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int warp_width(input int num_warps);
        return idx_width(num_warps);
    endfunction

    function automatic int reg_addr_width(input int num_regs);
        return idx_width(num_regs);
    endfunction

    // Clear sequencer states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Bit position of the read enable for (port, lane) in rd_en.
    function automatic int en_bit(input int port, input int lane, input int num_lanes);
        return port * num_lanes + lane;
    endfunction

    // LSB of the (port, lane) word in the flat rd_data bus (lane-major in port).
    function automatic int rd_slice(input int port, input int lane,
                                    input int num_lanes, input int data_w);
        return (port * num_lanes + lane) * data_w;
    endfunction

endpackage

// File: rtl/warp_regfile_lane.sv
// -----------------------------------------------------------------------------
// warp_regfile_lane
// Storage for a single SIMT lane: NUM_WARPS*NUM_REGS words of DATA_W bits,
// one write port and NUM_RD_PORTS registered read ports.
//
// Optional feature macro: WARP_REGFILE_BYPASS_EN
//   defined   : a read of the entry being written at the same edge returns
//               the incoming write data
//   undefined : such a read returns the pre-write contents
//
// Ports
//   clk, rst    clock / asynchronous active-high reset (read registers only)
//   we          write strobe, already gated and range-checked by the top
//   wr_warp     write warp
//   wr_addr     write register
//   wr_data     write word
//   rd_en       per-port read enable for this lane
//   rd_warp     per-port warp select (flat)
//   rd_addr     per-port register address (flat)
//   rd_data     per-port registered read word (flat), 0 when not enabled
// -----------------------------------------------------------------------------
module warp_regfile_lane
    import warp_regfile_pkg::*;
#(
    parameter int NUM_WARPS    = 8,
    parameter int NUM_REGS     = 64,
    parameter int DATA_W       = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int WARP_W       = 3,
    parameter int REG_AW       = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [WARP_W-1:0]                wr_warp,
    input  logic [REG_AW-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic [NUM_RD_PORTS-1:0]          rd_en,
    input  logic [NUM_RD_PORTS*WARP_W-1:0]   rd_warp,
    input  logic [NUM_RD_PORTS*REG_AW-1:0]   rd_addr,
    output logic [NUM_RD_PORTS*DATA_W-1:0]   rd_data
);

    localparam int DEPTH = NUM_WARPS * NUM_REGS;
    localparam int IDX_W = idx_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  widx;

    function automatic logic [IDX_W-1:0] entry(input logic [WARP_W-1:0] w,
                                               input logic [REG_AW-1:0] a);
        return IDX_W'(32'(w) * NUM_REGS + 32'(a));
    endfunction

    assign widx = entry(wr_warp, wr_addr);

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [WARP_W-1:0] r_warp;
        logic [REG_AW-1:0] r_addr;
        logic [IDX_W-1:0]  ridx;
        logic              in_range;
        logic [DATA_W-1:0] rval;
        logic [DATA_W-1:0] rd_q;

        assign r_warp   = rd_warp[p*WARP_W +: WARP_W];
        assign r_addr   = rd_addr[p*REG_AW +: REG_AW];
        assign ridx     = entry(r_warp, r_addr);
        // Only matters for non-power-of-two NUM_WARPS / NUM_REGS.
        assign in_range = (32'(r_warp) < NUM_WARPS) && (32'(r_addr) < NUM_REGS);

`ifdef WARP_REGFILE_BYPASS_EN
        // we is only ever asserted for an in-range entry, so an index match
        // means the same architectural register.
        assign rval = (we && (ridx == widx)) ? wr_data : mem[ridx];
`else
        assign rval = mem[ridx];
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q <= '0;
            end else if (rd_en[p] && in_range) begin
                rd_q <= rval;
            end else begin
                rd_q <= '0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = rd_q;
    end

endmodule

// File: rtl/warp_register_file.sv
// -----------------------------------------------------------------------------
// warp_register_file
// Per-warp, per-lane SIMT register file with NUM_RD_PORTS registered read
// ports, one lane-masked write port and a hardware warp-clear sequencer.
//
// Optional feature macro: WARP_REGFILE_BYPASS_EN (same-edge write-to-read
// forwarding, including the zero writes of a clear sequence).
//
// Ports
//   clk, rst   clock / asynchronous active-high reset
//   rd_en      per-port, per-lane read enable (bit p*NUM_LANES+l)
//   rd_warp    per-port warp select
//   rd_addr    per-port register address
//   rd_data    read data, lane-major within port, one cycle after request
//   rd_valid   per-port: data returned this cycle
//   wr_en      per-lane write mask (ignored while busy)
//   wr_warp    write warp
//   wr_addr    write register
//   wr_data    write data, lane l at [l*DATA_W +: DATA_W]
//   clr_req    start zeroing every register of clr_warp
//   clr_warp   warp to clear
//   busy       clear sequence running
//   clr_done   one-cycle pulse coincident with the final clear write
// -----------------------------------------------------------------------------
module warp_register_file
    import warp_regfile_pkg::*;
#(
    parameter  int NUM_WARPS    = 8,
    parameter  int NUM_LANES    = 8,
    parameter  int NUM_REGS     = 64,
    parameter  int DATA_W       = 32,
    parameter  int NUM_RD_PORTS = 2,
    localparam int WARP_W       = warp_width(NUM_WARPS),
    localparam int REG_AW       = reg_addr_width(NUM_REGS)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_RD_PORTS*NUM_LANES-1:0]        rd_en,
    input  logic [NUM_RD_PORTS*WARP_W-1:0]           rd_warp,
    input  logic [NUM_RD_PORTS*REG_AW-1:0]           rd_addr,
    output logic [NUM_RD_PORTS*NUM_LANES*DATA_W-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]                  rd_valid,
    input  logic [NUM_LANES-1:0]                     wr_en,
    input  logic [WARP_W-1:0]                        wr_warp,
    input  logic [REG_AW-1:0]                        wr_addr,
    input  logic [NUM_LANES*DATA_W-1:0]              wr_data,
    input  logic                                     clr_req,
    input  logic [WARP_W-1:0]                        clr_warp,
    output logic                                     busy,
    output logic                                     clr_done
);

    clr_state_t        state;
    logic [REG_AW-1:0] counter;
    logic [WARP_W-1:0] clr_warp_q;

    // Clear sequencer. busy / clr_done are registered alongside the state so
    // busy is high for exactly NUM_REGS cycles and clr_done marks the cycle
    // whose closing edge writes the last register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            clr_warp_q <= '0;
            busy       <= 1'b0;
            clr_done   <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state      <= CLEAR;
                        clr_warp_q <= clr_warp;
                        counter    <= '0;
                        busy       <= 1'b1;
                        clr_done   <= (NUM_REGS == 1);
                    end
                end
                CLEAR: begin
                    if (counter == REG_AW'(NUM_REGS - 1)) begin
                        state   <= IDLE;
                        counter <= '0;
                        busy    <= 1'b0;
                    end else begin
                        counter  <= counter + REG_AW'(1);
                        clr_done <= (32'(counter) + 2 == NUM_REGS);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic              clr_active;
    logic              wr_ok;
    logic [WARP_W-1:0] lane_wwarp;
    logic [REG_AW-1:0] lane_waddr;

    assign clr_active = (state == CLEAR);
    // Out-of-range write targets are dropped rather than aliased.
    assign wr_ok      = (32'(wr_warp) < NUM_WARPS) && (32'(wr_addr) < NUM_REGS);
    assign lane_wwarp = clr_active ? clr_warp_q : wr_warp;
    assign lane_waddr = clr_active ? counter : wr_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= '0;
        end else begin
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                rd_valid[p] <= |rd_en[p*NUM_LANES +: NUM_LANES];
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [NUM_RD_PORTS-1:0]        lane_rd_en;
        logic [NUM_RD_PORTS*DATA_W-1:0] lane_rd_data;
        logic                           lane_we;
        logic [DATA_W-1:0]              lane_wdata;

        for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
            assign lane_rd_en[p] = rd_en[en_bit(p, l, NUM_LANES)];
            assign rd_data[rd_slice(p, l, NUM_LANES, DATA_W) +: DATA_W] =
                lane_rd_data[p*DATA_W +: DATA_W];
        end

        // The clear owns the write port in every lane while it runs.
        assign lane_we    = clr_active | (wr_en[l] & wr_ok);
        assign lane_wdata = clr_active ? '0 : wr_data[l*DATA_W +: DATA_W];

        warp_regfile_lane #(
            .NUM_WARPS    (NUM_WARPS),
            .NUM_REGS     (NUM_REGS),
            .DATA_W       (DATA_W),
            .NUM_RD_PORTS (NUM_RD_PORTS),
            .WARP_W       (WARP_W),
            .REG_AW       (REG_AW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .we      (lane_we),
            .wr_warp (lane_wwarp),
            .wr_addr (lane_waddr),
            .wr_data (lane_wdata),
            .rd_en   (lane_rd_en),
            .rd_warp (rd_warp),
            .rd_addr (rd_addr),
            .rd_data (lane_rd_data)
        );
    end

endmodule
